// File: rtl/scan_mux_pkg.sv
// Shared types and helpers for the scanning channel multiplexer.
// Holds the block state encoding, the mode input encodings and a width helper.
package scan_mux_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Bits needed to index 'value' items; never less than one bit.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Dwell counter for the scan pointer: counts 0..DWELL-1 while run is high
// and raises tick on the terminal count; clear forces the count back to 0.
module scan_tick_gen
    import scan_mux_pkg::*;
#(
    parameter int DWELL = 1000
) (
    input  logic clk,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int CNT_WIDTH = clog2(DWELL);
    localparam logic [CNT_WIDTH-1:0] TERMINAL = CNT_WIDTH'(DWELL - 1);

    logic [CNT_WIDTH-1:0] count;

    assign tick = run && (count == TERMINAL);

    // A frozen count (run low, clear low) resumes exactly where it stopped.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/scan_mux.sv
// Registered N-to-1 channel multiplexer with manual selection or timed
// round-robin scanning, plus one-hot/binary channel flags and a wrap pulse.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter  int DATA_WIDTH = 7,
    parameter  int CHANNELS   = 8,
    parameter  int DWELL      = 1000,
    localparam int SEL_WIDTH  = clog2(CHANNELS)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic [SEL_WIDTH-1:0]           select,
    input  logic                           mode,
    input  logic                           enable,
    input  logic                           hold,
    output logic [DATA_WIDTH-1:0]          out,
    output logic [CHANNELS-1:0]            chan_onehot,
    output logic [SEL_WIDTH-1:0]           chan_index,
    output logic                           out_valid,
    output logic                           wrap
);

    localparam logic [SEL_WIDTH-1:0] LAST_CHAN = SEL_WIDTH'(CHANNELS - 1);
    localparam logic [CHANNELS-1:0]  ONE_HOT0  = CHANNELS'(1);

    state_t                 state_q;
    state_t                 state_d;
    logic [SEL_WIDTH-1:0]   ptr_q;
    logic [SEL_WIDTH-1:0]   ptr_d;
    logic [SEL_WIDTH-1:0]   idx_d;
    logic                   valid_d;
    logic                   wrap_d;
    logic [DATA_WIDTH-1:0]  out_d;
    logic [CHANNELS-1:0]    onehot_d;
    logic                   sel_legal;
    logic                   scan_continue;
    logic                   tick_clear;
    logic                   tick_run;
    logic                   tick;

    assign sel_legal = (int'(select) < CHANNELS);

    always_comb begin
        state_d = OFF;
        if (enable) begin
            state_d = (mode == MODE_SCAN) ? SCAN : MANUAL;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // The first cycle of any scan run only loads the pointer, so every
    // entry into SCAN (including after reset) starts with a full dwell.
    assign scan_continue = (state_d == SCAN) && (state_q == SCAN);
    assign tick_clear    = !reset_n || !scan_continue;
    assign tick_run      = reset_n && scan_continue && !hold;

    scan_tick_gen #(
        .DWELL (DWELL)
    ) u_tick_gen (
        .clk   (clk),
        .clear (tick_clear),
        .run   (tick_run),
        .tick  (tick)
    );

    always_comb begin
        ptr_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        case (state_d)
            MANUAL: begin
                if (sel_legal) begin
                    idx_d   = select;
                    valid_d = 1'b1;
                end
            end
            SCAN: begin
                if (state_q != SCAN) begin
                    ptr_d = (state_q == MANUAL && sel_legal) ? select : '0;
                end else if (tick) begin
                    ptr_d  = (ptr_q == LAST_CHAN) ? '0 : ptr_q + 1'b1;
                    wrap_d = (ptr_q == LAST_CHAN);
                end else begin
                    ptr_d = ptr_q;
                end
                idx_d   = ptr_d;
                valid_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign out_d    = valid_d ? in_data[idx_d*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign onehot_d = valid_d ? (ONE_HOT0 << idx_d) : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q       <= '0;
            out         <= '0;
            chan_onehot <= '0;
            chan_index  <= '0;
            out_valid   <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out         <= out_d;
            chan_onehot <= onehot_d;
            chan_index  <= idx_d;
            out_valid   <= valid_d;
            wrap        <= wrap_d;
        end
    end

endmodule
